counter_monitor: RTL

//   Downstream consumer of the free-running up-counter output bus.
//   - Samples the counter value on each qualified clock edge.
//   - Checks that every sample is a legal step (hold, +1, or a jump to 0 on upstream reset).
//   - Counts wrap-arounds (max -> 0) and flags, then captures, the first illegal step.
//   - Feeds the status/debug logic.

---
 rtl/counter_monitor.sv | 109 ++++++++++
 1 files changed

// File: rtl/counter_monitor.sv
// Checks the sample stream of an upstream free-running up-counter for legal steps.
// It also counts max->0 wraps and captures the first illegal step.
module counter_monitor #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic              clear_err,
  output logic              wrap_pulse,
  output logic              rst_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              step_err,
  output logic [WIDTH-1:0]  err_prev,
  output logic [WIDTH-1:0]  err_value
);

  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] delta;
  logic             is_step, is_wrap, is_resync, is_fault;
  logic             wrap_nxt, rst_nxt, count_en, capture, err_set, err_clr;

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] val);
    return (&val) ? val : val + 1'b1;
  endfunction

  // Classification of the current sample against the previous one
  always_comb begin
    delta     = cnt_in - prev;
    is_step   = (delta == CNT_ONE);
    is_wrap   = is_step && (prev == CNT_MAX) && (cnt_in == '0);
    is_resync = (cnt_in == '0) && !is_step && (prev != '0);
    is_fault  = (delta != '0) && !is_step && !is_resync;
  end

  always_comb begin
    state_nxt = state;
    wrap_nxt  = 1'b0;
    rst_nxt   = 1'b0;
    count_en  = 1'b0;
    capture   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    if (cnt_valid) begin
      case (state)
        IDLE: state_nxt = TRACK;
        TRACK: begin
          wrap_nxt = is_wrap;
          rst_nxt  = is_resync;
          count_en = is_wrap;
          if (is_fault) begin
            capture   = 1'b1;
            err_set   = 1'b1;
            state_nxt = ERROR;
          end
        end
        ERROR: begin
          wrap_nxt = is_wrap;
          rst_nxt  = is_resync;
          count_en = is_wrap;
          // A fault arriving with the clear request keeps the error and refreshes the capture
          if (clear_err) begin
            if (is_fault) begin
              capture = 1'b1;
            end else begin
              err_clr   = 1'b1;
              state_nxt = TRACK;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      wrap_pulse <= 1'b0;
      rst_pulse  <= 1'b0;
      wrap_count <= '0;
      step_err   <= 1'b0;
      err_prev   <= '0;
      err_value  <= '0;
    end else begin
      state      <= state_nxt;
      wrap_pulse <= wrap_nxt;
      rst_pulse  <= rst_nxt;
      if (cnt_valid) prev <= cnt_in;
      if (count_en) wrap_count <= sat_inc(wrap_count);
      if (err_set) step_err <= 1'b1;
      else if (err_clr) step_err <= 1'b0;
      if (capture) begin
        err_prev  <= prev;
        err_value <= cnt_in;
      end
    end
  end

endmodule
